target_clock_enable_ctrl: RTL and testbench
===========================================

Name: target_clock_enable_ctrl

Overview:
- Token-driven enable generator that sits directly upstream of the gated target-clock buffer and drives its CE input.
- Advances the target clock one cycle per host cycle only when three conditions hold: an input token is present, the output token slot can accept a token, and the cycle budget is not exhausted.
- Software loads a cycle budget. The block runs until the budget is spent or halt is asserted, then drains and reports done.

Parameters:
- BUDGET_WIDTH, 32, width of the loadable cycle budget and the remaining-cycles counter.
- CYCLE_WIDTH, 64, width of the free-running fired-target-cycle counter.

Ports:
- clock  in  1  host clock.
- reset  in  1  synchronous, active-high reset.
- budget_valid  in  1  budget load request.
- budget_ready  out  1  high only in IDLE.
- budget_cycles  in  BUDGET_WIDTH  number of target cycles to run.
- halt  in  1  level; abort the run after the current host cycle.
- in_valid  in  1  input token available.
- in_ready  out  1  input token consumed this cycle (equals fire).
- out_valid  out  1  output token held in slot.
- out_ready  in  1  consumer accepts output token.
- ce  out  1  registered enable to the clock buffer CE.
- cycle_count  out  CYCLE_WIDTH  total fired target cycles.
- remaining  out  BUDGET_WIDTH  cycles left in the current run.
- done  out  1  one-cycle pulse on the DRAIN to IDLE transition.

Behaviour:
- Reset values: state IDLE, ce=0, out_valid=0, remaining=0, cycle_count=0, done=0.
- fire (combinational) = state==RUN && !halt && remaining!=0 && in_valid && (!out_valid || out_ready).
- in_ready = fire. in_ready never depends on out_valid alone, and never asserts outside RUN.
- ce is registered: ce <= fire. The clock buffer therefore sees one host-cycle latency, and exactly one ce pulse occurs per fire.
- On fire:
  - remaining <= remaining-1
  - cycle_count <= cycle_count+1 (wraps modulo 2^CYCLE_WIDTH)
  - output slot loads a token: out_valid <= 1
- Output slot update:
  - out_valid <= fire | (out_valid & !out_ready).
  - Simultaneous out_ready and fire: old token leaves and new token enters; out_valid stays 1.
- IDLE:
  - budget_ready=1.
  - On budget_valid: remaining <= budget_cycles.
  - Go to RUN if budget_cycles!=0; otherwise stay IDLE and pulse done next cycle.
- RUN:
  - If halt: remaining <= 0, go to DRAIN. A fire is impossible in this cycle because fire includes !halt.
  - Else if fire and remaining==1: go to DRAIN.
  - Else stay in RUN.
- DRAIN:
  - No fire.
  - When out_valid==0, or out_valid && out_ready: go to IDLE and pulse done.
- ce is 0 in every state except the cycle after a fire.
- Budget loads are ignored outside IDLE.
- halt asserted while in IDLE or DRAIN has no effect.
- Reset asserted mid-run returns all state to reset values in the next cycle. A pending output token is dropped.
- remaining never underflows: fire requires remaining!=0.

Decomposition:
- Shared package holds:
  - state enum: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2
  - default widths BUDGET_WIDTH and CYCLE_WIDTH
- One natural sub-module: token_slot. It is a one-entry valid/ready holding register with a load strobe and out_valid/out_ready, with the same reset behaviour as above.

Test Plan:
- Load budget_cycles=5 with in_valid=1 and out_ready=1 held high → 5 consecutive fires; ce high for 5 cycles starting 1 cycle after the first fire; cycle_count=5, remaining=0; done pulses once; state returns to IDLE.
- budget=4, in_valid toggling 1,0,1,0,... → fires only on in_valid cycles; ce pulses mirror them delayed by 1 cycle; cycle_count=4 after 8 host cycles.
- budget=3, out_ready=0 → exactly one fire; out_valid=1 and held; in_ready=0 until out_ready rises; raise out_ready → the remaining 2 fires proceed back-to-back.
- budget=10, assert halt after 3 fires → no further fire or ce after the halt cycle; remaining=0; done pulses after the output token drains; cycle_count=3.
- Load budget=0 → no fire and no ce; done pulses next cycle; state stays IDLE. Attempted load during RUN → ignored and remaining unchanged.
- Assert reset mid-run with out_valid=1 → next cycle: ce=0, out_valid=0, cycle_count=0, remaining=0, state IDLE.

Source files
------------

// File: rtl/target_clock_enable_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// target_clock_enable_ctrl_pkg
// Shared types and default widths for the target clock-enable controller.
//   state_t              : controller FSM encoding (IDLE / RUN / DRAIN)
//   DEFAULT_BUDGET_WIDTH : width of the loadable budget and remaining counter
//   DEFAULT_CYCLE_WIDTH  : width of the free-running fired-cycle counter
// -----------------------------------------------------------------------------
package target_clock_enable_ctrl_pkg;

  localparam int unsigned DEFAULT_BUDGET_WIDTH = 32;
  localparam int unsigned DEFAULT_CYCLE_WIDTH  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage : target_clock_enable_ctrl_pkg

// File: rtl/target_clock_enable_ctrl_if.sv
// -----------------------------------------------------------------------------
// target_clock_enable_ctrl_if
// Bundles the budget-load handshake, token handshakes and status outputs of
// the clock-enable controller.
//   slave  : controller view (drives budget_ready, in_ready, out_valid, ce,
//            cycle_count, remaining, done)
//   master : host/environment view (drives budget_valid, budget_cycles, halt,
//            in_valid, out_ready)
// -----------------------------------------------------------------------------
interface target_clock_enable_ctrl_if #(
  parameter int unsigned BUDGET_WIDTH = target_clock_enable_ctrl_pkg::DEFAULT_BUDGET_WIDTH,
  parameter int unsigned CYCLE_WIDTH  = target_clock_enable_ctrl_pkg::DEFAULT_CYCLE_WIDTH
) ();

  logic                    budget_valid;
  logic                    budget_ready;
  logic [BUDGET_WIDTH-1:0] budget_cycles;
  logic                    halt;
  logic                    in_valid;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic                    ce;
  logic [CYCLE_WIDTH-1:0]  cycle_count;
  logic [BUDGET_WIDTH-1:0] remaining;
  logic                    done;

  modport slave (
    input  budget_valid, budget_cycles, halt, in_valid, out_ready,
    output budget_ready, in_ready, out_valid, ce, cycle_count, remaining, done
  );

  modport master (
    output budget_valid, budget_cycles, halt, in_valid, out_ready,
    input  budget_ready, in_ready, out_valid, ce, cycle_count, remaining, done
  );

endinterface : target_clock_enable_ctrl_if

// File: rtl/target_clock_enable_ctrl_token_slot.sv
// -----------------------------------------------------------------------------
// target_clock_enable_ctrl_token_slot
// One-entry valid/ready output token holder.
//   i_clock     : host clock
//   i_reset     : synchronous active-high reset (drops any held token)
//   i_load      : a new token enters this cycle
//   i_out_ready : consumer accepts the held token this cycle
//   o_out_valid : a token is held
// A load and a consume in the same cycle replace the token, so the slot
// stays full.
// -----------------------------------------------------------------------------
module target_clock_enable_ctrl_token_slot (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_out_ready,
  output logic o_out_valid
);

  logic r_valid;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_load | (r_valid & ~i_out_ready);
    end
  end

  assign o_out_valid = r_valid;

endmodule : target_clock_enable_ctrl_token_slot

// File: rtl/target_clock_enable_ctrl.sv
// -----------------------------------------------------------------------------
// target_clock_enable_ctrl
// Token-driven enable generator for a gated target-clock buffer. One target
// cycle fires per host cycle while a run is active, an input token is
// present, the output slot can take a token and budget remains.
//   clock : host clock
//   reset : synchronous active-high reset
//   bus   : slave modport of target_clock_enable_ctrl_if
//           budget_valid/budget_ready/budget_cycles : budget load (IDLE only)
//           halt                                    : abort the current run
//           in_valid/in_ready                       : input token (in_ready = fire)
//           out_valid/out_ready                     : output token slot
//           ce                                      : registered clock enable
//           cycle_count, remaining, done            : status
// -----------------------------------------------------------------------------
module target_clock_enable_ctrl
  import target_clock_enable_ctrl_pkg::*;
#(
  parameter int unsigned BUDGET_WIDTH = DEFAULT_BUDGET_WIDTH,
  parameter int unsigned CYCLE_WIDTH  = DEFAULT_CYCLE_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  target_clock_enable_ctrl_if.slave bus
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [BUDGET_WIDTH-1:0] r_remaining;
  logic [CYCLE_WIDTH-1:0]  r_cycle_count;
  logic                    r_ce;
  logic                    r_done;

  logic w_fire;
  logic w_out_valid;
  logic w_slot_free;
  logic w_done_next;
  logic w_load;

  // The slot can accept when empty, or when its token leaves this same cycle.
  assign w_slot_free = ~w_out_valid | bus.out_ready;

  // remaining != 0 guards against underflow; !halt keeps the halt cycle clean.
  assign w_fire = (r_state == RUN) && !bus.halt && (r_remaining != '0) &&
                  bus.in_valid && w_slot_free;

  assign w_load = (r_state == IDLE) && bus.budget_valid;

  target_clock_enable_ctrl_token_slot u_token_slot (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_load      (w_fire),
    .i_out_ready (bus.out_ready),
    .o_out_valid (w_out_valid)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.budget_valid) begin
          if (bus.budget_cycles != '0) begin
            w_state_next = RUN;
          end else begin
            // Empty budget: the run is complete before it starts.
            w_done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.halt) begin
          w_state_next = DRAIN;
        end else if (w_fire && (r_remaining == BUDGET_WIDTH'(1))) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Leave once the last token is gone or is leaving this cycle.
        if (w_slot_free) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_remaining   <= '0;
      r_cycle_count <= '0;
      r_ce          <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ce    <= w_fire;
      r_done  <= w_done_next;

      if (w_load) begin
        r_remaining <= bus.budget_cycles;
      end else if ((r_state == RUN) && bus.halt) begin
        r_remaining <= '0;
      end else if (w_fire) begin
        r_remaining <= r_remaining - BUDGET_WIDTH'(1);
      end

      if (w_fire) begin
        r_cycle_count <= r_cycle_count + CYCLE_WIDTH'(1);
      end
    end
  end

  assign bus.budget_ready = (r_state == IDLE);
  assign bus.in_ready     = w_fire;
  assign bus.out_valid    = w_out_valid;
  assign bus.ce           = r_ce;
  assign bus.cycle_count  = r_cycle_count;
  assign bus.remaining    = r_remaining;
  assign bus.done         = r_done;

endmodule : target_clock_enable_ctrl

// File: tb/tb_target_clock_enable_ctrl.sv
// -----------------------------------------------------------------------------
// tb_target_clock_enable_ctrl
// Directed self-checking bench for target_clock_enable_ctrl. Inputs change
// 1 time unit after a rising edge; combinational outputs are sampled before
// the next edge and registered outputs 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_target_clock_enable_ctrl;

  logic clock;
  logic reset;

  int n_compared;
  int n_mismatched;

  // Per-cycle capture: bit i belongs to cycle i of a capture window.
  logic [15:0] fire_pat;
  logic [15:0] ce_pat;
  logic [15:0] done_pat;
  logic [15:0] ov_pat;

  target_clock_enable_ctrl_if bus ();

  target_clock_enable_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    bus.budget_valid  = 1'b0;
    bus.budget_cycles = '0;
    bus.halt          = 1'b0;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [31:0] budget);
    bus.budget_valid  = 1'b1;
    bus.budget_cycles = budget;
    tick();
    bus.budget_valid  = 1'b0;
  endtask

  task automatic capture(input int n, input logic [15:0] iv,
                         input logic [15:0] ordy, input logic [15:0] hlt);
    fire_pat = '0;
    ce_pat   = '0;
    done_pat = '0;
    ov_pat   = '0;
    for (int i = 0; i < n; i++) begin
      bus.in_valid  = iv[i];
      bus.out_ready = ordy[i];
      bus.halt      = hlt[i];
      #1;
      fire_pat[i] = bus.in_ready;
      ov_pat[i]   = bus.out_valid;
      tick();
      ce_pat[i]   = bus.ce;
      done_pat[i] = bus.done;
    end
    bus.halt = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    do_reset();
    n_compared++; if (bus.ce !== 1'b0) begin n_mismatched++; $display("FAIL reset_ce: got %b want 0", bus.ce); end
    n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_compared++; if (bus.remaining !== 32'd0) begin n_mismatched++; $display("FAIL reset_remaining: got %0d want 0", bus.remaining); end
    n_compared++; if (bus.cycle_count !== 64'd0) begin n_mismatched++; $display("FAIL reset_cycle_count: got %0d want 0", bus.cycle_count); end
    n_compared++; if (bus.done !== 1'b0) begin n_mismatched++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_compared++; if (bus.budget_ready !== 1'b1) begin n_mismatched++; $display("FAIL reset_budget_ready: got %b want 1", bus.budget_ready); end
    n_compared++; if (bus.in_ready !== 1'b0) begin n_mismatched++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
  endtask

  task automatic test_full_run;
    do_reset();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_compared++; if (bus.in_ready !== 1'b0) begin n_mismatched++; $display("FAIL full_idle_in_ready: got %b want 0", bus.in_ready); end
    load(32'd5);
    n_compared++; if (bus.remaining !== 32'd5) begin n_mismatched++; $display("FAIL full_loaded: got %0d want 5", bus.remaining); end
    n_compared++; if (bus.budget_ready !== 1'b0) begin n_mismatched++; $display("FAIL full_run_busy: got %b want 0", bus.budget_ready); end
    capture(8, 16'hFFFF, 16'hFFFF, 16'h0000);
    n_compared++; if (fire_pat !== 16'h001F) begin n_mismatched++; $display("FAIL full_fire: got %h want 001f", fire_pat); end
    n_compared++; if (ce_pat !== 16'h001F) begin n_mismatched++; $display("FAIL full_ce: got %h want 001f", ce_pat); end
    n_compared++; if (done_pat !== 16'h0020) begin n_mismatched++; $display("FAIL full_done: got %h want 0020", done_pat); end
    n_compared++; if (bus.cycle_count !== 64'd5) begin n_mismatched++; $display("FAIL full_count: got %0d want 5", bus.cycle_count); end
    n_compared++; if (bus.remaining !== 32'd0) begin n_mismatched++; $display("FAIL full_remaining: got %0d want 0", bus.remaining); end
    n_compared++; if (bus.budget_ready !== 1'b1) begin n_mismatched++; $display("FAIL full_idle: got %b want 1", bus.budget_ready); end
  endtask

  task automatic test_toggle;
    do_reset();
    load(32'd4);
    capture(10, 16'h5555, 16'hFFFF, 16'h0000);
    n_compared++; if (fire_pat !== 16'h0055) begin n_mismatched++; $display("FAIL toggle_fire: got %h want 0055", fire_pat); end
    n_compared++; if (ce_pat !== 16'h0055) begin n_mismatched++; $display("FAIL toggle_ce: got %h want 0055", ce_pat); end
    n_compared++; if (done_pat !== 16'h0080) begin n_mismatched++; $display("FAIL toggle_done: got %h want 0080", done_pat); end
    n_compared++; if (bus.cycle_count !== 64'd4) begin n_mismatched++; $display("FAIL toggle_count: got %0d want 4", bus.cycle_count); end
  endtask

  task automatic test_backpressure;
    do_reset();
    load(32'd3);
    capture(8, 16'hFFFF, 16'hFFF0, 16'h0000);
    n_compared++; if (fire_pat !== 16'h0031) begin n_mismatched++; $display("FAIL bp_fire: got %h want 0031", fire_pat); end
    n_compared++; if (ce_pat !== 16'h0031) begin n_mismatched++; $display("FAIL bp_ce: got %h want 0031", ce_pat); end
    n_compared++; if (ov_pat !== 16'h007E) begin n_mismatched++; $display("FAIL bp_out_valid: got %h want 007e", ov_pat); end
    n_compared++; if (done_pat !== 16'h0040) begin n_mismatched++; $display("FAIL bp_done: got %h want 0040", done_pat); end
    n_compared++; if (bus.cycle_count !== 64'd3) begin n_mismatched++; $display("FAIL bp_count: got %0d want 3", bus.cycle_count); end
  endtask

  task automatic test_halt;
    do_reset();
    load(32'd10);
    capture(9, 16'hFFFF, 16'hFFC7, 16'hFFF8);
    n_compared++; if (fire_pat !== 16'h0007) begin n_mismatched++; $display("FAIL halt_fire: got %h want 0007", fire_pat); end
    n_compared++; if (ce_pat !== 16'h0007) begin n_mismatched++; $display("FAIL halt_ce: got %h want 0007", ce_pat); end
    n_compared++; if (ov_pat !== 16'h007E) begin n_mismatched++; $display("FAIL halt_out_valid: got %h want 007e", ov_pat); end
    n_compared++; if (done_pat !== 16'h0040) begin n_mismatched++; $display("FAIL halt_done: got %h want 0040", done_pat); end
    n_compared++; if (bus.remaining !== 32'd0) begin n_mismatched++; $display("FAIL halt_remaining: got %0d want 0", bus.remaining); end
    n_compared++; if (bus.cycle_count !== 64'd3) begin n_mismatched++; $display("FAIL halt_count: got %0d want 3", bus.cycle_count); end
  endtask

  task automatic test_zero_and_ignored_load;
    do_reset();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    load(32'd0);
    n_compared++; if (bus.done !== 1'b1) begin n_mismatched++; $display("FAIL zero_done: got %b want 1", bus.done); end
    n_compared++; if (bus.budget_ready !== 1'b1) begin n_mismatched++; $display("FAIL zero_idle: got %b want 1", bus.budget_ready); end
    capture(4, 16'hFFFF, 16'hFFFF, 16'h0000);
    n_compared++; if ({fire_pat, ce_pat} !== 32'h0) begin n_mismatched++; $display("FAIL zero_no_fire: got %h/%h want 0000/0000", fire_pat, ce_pat); end
    n_compared++; if (done_pat !== 16'h0000) begin n_mismatched++; $display("FAIL zero_single_done: got %h want 0000", done_pat); end

    // Load attempted while running must be ignored.
    bus.in_valid = 1'b0;
    load(32'd6);
    bus.budget_valid  = 1'b1;
    bus.budget_cycles = 32'd99;
    tick();
    bus.budget_valid  = 1'b0;
    n_compared++; if (bus.remaining !== 32'd6) begin n_mismatched++; $display("FAIL run_load_ignored: got %0d want 6", bus.remaining); end
    n_compared++; if (bus.budget_ready !== 1'b0) begin n_mismatched++; $display("FAIL run_budget_ready: got %b want 0", bus.budget_ready); end
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    tick();
    n_compared++; if (bus.done !== 1'b1) begin n_mismatched++; $display("FAIL halt_empty_done: got %b want 1", bus.done); end
  endtask

  task automatic test_reset_mid_run;
    do_reset();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    load(32'd8);
    tick();
    n_compared++; if ({bus.out_valid, bus.ce} !== 2'b11) begin n_mismatched++; $display("FAIL midrst_pre: got %b want 11", {bus.out_valid, bus.ce}); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_compared++; if (bus.ce !== 1'b0) begin n_mismatched++; $display("FAIL midrst_ce: got %b want 0", bus.ce); end
    n_compared++; if (bus.out_valid !== 1'b0) begin n_mismatched++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    n_compared++; if (bus.cycle_count !== 64'd0) begin n_mismatched++; $display("FAIL midrst_count: got %0d want 0", bus.cycle_count); end
    n_compared++; if (bus.remaining !== 32'd0) begin n_mismatched++; $display("FAIL midrst_remaining: got %0d want 0", bus.remaining); end
    n_compared++; if (bus.budget_ready !== 1'b1) begin n_mismatched++; $display("FAIL midrst_idle: got %b want 1", bus.budget_ready); end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_full_run();
    test_toggle();
    test_backpressure();
    test_halt();
    test_zero_and_ignored_load();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_target_clock_enable_ctrl
